mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the decoder's memory control fields: MemRW, RWType, and the load indication derived from MemtoReg==1.
- Converts each load/store into a word-aligned data-memory bus transaction with byte enables and lane-replicated store data. Stalls the pipeline until the bus acknowledges, then returns sign- or zero-extended load data to WB.
- Detects misaligned accesses, illegal RWType and bus timeout, and reports them instead of accessing memory.

Parameters:
- TIMEOUT, 16, maximum cycles in REQ without dmem_ack before a timeout error (≥1).
- TCW, 5, width of the timeout counter; must satisfy 2^TCW > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_valid  in  1  valid instruction present in MEM stage
- mem_read  in  1  load (MemtoReg==1)
- mem_write  in  1  store (MemRW)
- rw_type  in  3  fun3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  effective address from ALU
- wdata  in  32  store data (rs2)
- stall  out  1  hold IF/ID/EX/MEM registers
- done  out  1  one-cycle completion pulse; MEM advances this cycle
- load_data  out  32  extended load result, valid when done && mem_read && err==0
- err  out  2  valid with done: 0 none, 1 misaligned, 2 illegal type, 3 timeout
- dmem_req  out  1  bus request
- dmem_we  out  1  write strobe
- dmem_addr  out  32  {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  bus accept; for reads, rdata valid the same cycle
- dmem_rdata  in  32  read data

Behaviour:
- Reset (one clk edge with rst=1):
  - State goes to IDLE.
  - All outputs go to 0, including the bus signals, load_data and err.
  - Timeout counter goes to 0.
  - An in-flight request is abandoned; dmem_req is low on the first cycle after reset. A dmem_ack arriving later is ignored.
- start = mem_valid && (mem_read || mem_write). If mem_read and mem_write are both high, the access is treated as a store.
- stall (combinational) = (state==IDLE && start) || state==REQ. stall is 0 in DONE.
- IDLE:
  - On start with illegal rw_type, go to DONE with err=2. Illegal loads: 011, 11x. Illegal stores: any value other than 000/001/010.
  - Else on start with misalignment, go to DONE with err=1. Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Else go to REQ. Register dmem_addr, dmem_we, dmem_be and dmem_wdata; set dmem_req=1.
  - No bus access is made for error cases.
- REQ:
  - dmem_req and all bus outputs are held stable until the cycle dmem_ack=1.
  - On ack: go to DONE with err=0. Register dmem_req=0. For loads, register load_data from dmem_rdata.
  - Timeout counter increments each REQ cycle without ack. When it reaches TIMEOUT-1 with no ack: go to DONE with err=3 and drop dmem_req.
  - Ack and timeout in the same cycle: ack wins.
- DONE:
  - done=1 and stall=0 for exactly one cycle; the pipeline advances.
  - Return to IDLE. The counter clears.
  - The same instruction is never reissued, because the MEM inputs change at this edge.
  - err and load_data hold until the next DONE.
- Byte enables and store data:
  - B: be = 4'b0001 << addr[1:0]; dmem_wdata = {4{wdata[7:0]}}.
  - H: be = addr[1] ? 1100 : 0011; dmem_wdata = {2{wdata[15:0]}}.
  - W: be = 1111; dmem_wdata = wdata.
  - For loads, be uses the same lane rules and dmem_wdata is 0.
- Load extraction:
  - Byte lane is addr[1:0]; half lane is addr[1].
  - 000/001: sign-extend. 100/101: zero-extend. 010: full word.
- Latency: minimum 3 cycles from start to done (IDLE, REQ with immediate ack, DONE). Errors detected in IDLE take 2 cycles.
- Back-to-back accesses: IDLE evaluates the next instruction in the cycle after DONE; there are no bubbles beyond that.

Test Plan:
- SW addr=0x104, wdata=0xDEADBEEF, ack 2 cycles after req → dmem_addr=0x104, be=1111, we=1, stall high 3 cycles, done pulse with err=0.
- LB addr=0x203, rdata=0x80112233 → be=1000, load_data=0xFFFFFF80. LBU at the same address → 0x00000080.
- LH addr=0x202, rdata=0x8001_5555 → be=1100, load_data=0xFFFF8001. LHU addr=0x200, rdata=0x1234ABCD → 0x0000ABCD.
- SB addr=0x101, wdata=0xA5 → be=0010, dmem_wdata=0xA5A5A5A5.
- SH addr=0x101, and separately a store with rw_type=100 → no dmem_req, done after 2 cycles, err=1 and err=2 respectively.
- TIMEOUT=4, LW with no ack → dmem_req high 4 cycles, then done with err=3.
- Reset asserted mid-REQ, ack following → dmem_req=0 the next cycle, state IDLE, no done.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns one load/store into a word-aligned bus access and stalls the pipeline until it completes.
// Latency: 3 cycles minimum (IDLE, REQ, DONE), 2 cycles for errors detected in IDLE. Bus backpressure is dmem_ack; it times out after TIMEOUT REQ cycles.
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int TCW     = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  rw_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t         state, state_nxt;
    logic [TCW-1:0] tcnt;
    logic           start, illegal, misaligned, tmo_hit;
    logic [3:0]     be_c;
    logic [31:0]    wdata_c, ext_c, shifted;
    logic [15:0]    half;

    assign start   = mem_valid && (mem_read || mem_write);
    assign tmo_hit = (tcnt == TCW'(TIMEOUT - 1));
    assign stall   = (state == IDLE && start) || (state == REQ);
    assign done    = (state == DONE);

    // A store wins when both read and write are asserted.
    always_comb begin
        illegal = 1'b0;
        if (mem_write)
            illegal = !(rw_type == 3'b000 || rw_type == 3'b001 || rw_type == 3'b010);
        else
            illegal = (rw_type == 3'b011) || (rw_type[2:1] == 2'b11);
    end

    assign misaligned = ((rw_type[1:0] == 2'b01) && addr[0]) ||
                        ((rw_type[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata;
        case (rw_type[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_c    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wdata[15:0]}};
            end
            default: ;
        endcase
        if (!mem_write)
            wdata_c = 32'd0;
    end

    // addr/rw_type are still valid in REQ because the pipeline is stalled.
    assign shifted = dmem_rdata >> {addr[1:0], 3'b000};
    assign half    = addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (rw_type)
            3'b000:  ext_c = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext_c = {{16{half[15]}}, half};
            3'b100:  ext_c = {24'd0, shifted[7:0]};
            3'b101:  ext_c = {16'd0, half};
            default: ext_c = dmem_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (illegal || misaligned) ? DONE : REQ;
            REQ:     if (dmem_ack || tmo_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tcnt       <= '0;
            load_data  <= 32'd0;
            err        <= 2'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (start) begin
                        if (illegal)
                            err <= 2'd2;
                        else if (misaligned)
                            err <= 2'd1;
                        else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= {addr[31:2], 2'b00};
                            dmem_be    <= be_c;
                            dmem_wdata <= wdata_c;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        err      <= 2'd0;
                        if (!dmem_we)
                            load_data <= ext_c;
                    end else if (tmo_hit) begin
                        dmem_req <= 1'b0;
                        err      <= 2'd3;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: tcnt <= '0;
            endcase
        end
    end
endmodule
